// File: rtl/display_pkg.sv
// Shared definitions for the display scan multiplexer.
//   NUM_DIGITS : number of multiplexed digits
//   scan_idx_t : scan index type (selects digit 0..3)
//   AN_OFF     : all anodes dark (active-low)
//   AN_SEL     : active-low one-hot anode pattern per scan index
//   nibble_at  : extracts the nibble for a given scan index
package display_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [1:0] scan_idx_t;

   localparam logic [3:0] AN_OFF = 4'b1111;

   // AN_SEL[0] = 4'b1110 ... AN_SEL[3] = 4'b0111
   localparam logic [3:0][3:0] AN_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   function automatic logic [3:0] nibble_at(input logic [15:0] word, input scan_idx_t idx);
      return word[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/display_prescaler.sv
// Modulo-DIV counter with a one-cycle terminal-count pulse.
//   clk   : system clock
//   reset : synchronous active-high reset, clears the count
//   en    : advance the count this cycle
//   tc    : high while en=1 and the count sits at DIV-1 (wraps on this edge)
module display_prescaler #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tc
);

   // Keep at least one bit so DIV=1 still elaborates cleanly.
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   assign tc = en && (count_reg == CW'(DIV - 1));

   always_comb begin
      count_next = count_reg;
      if (en) begin
         count_next = tc ? '0 : count_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexes four nibbles onto one 7-segment decoder input.
//   clk        : system clock
//   reset      : synchronous active-high reset
//   digits_in  : four nibbles, [3:0] = digit0 (rightmost)
//   load       : one-cycle strobe capturing digits_in / dp_in
//   dp_in      : decimal point request per digit (active-high)
//   blink_mask : live per-digit blink enable
//   lz_blank   : live leading-zero blanking enable
//   digit_out  : nibble for the decoder (valid even when blanked)
//   an         : active-low anodes, at most one low
//   dp         : active-low decimal point
//   frame_tick : one-cycle pulse after each frame boundary
// New values are staged in a pending register and only moved to the
// displayed register at a frame boundary, so a frame never mixes values.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 125
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits_in,
   input  logic        load,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  blink_mask,
   input  logic        lz_blank,
   output logic [3:0]  digit_out,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_tick
);

   logic        slot_end;
   logic        frame_end;
   logic        blink_wrap;

   scan_idx_t   idx_reg;
   logic [15:0] disp_digits_reg;
   logic [3:0]  disp_dp_reg;
   logic [15:0] pend_digits_reg;
   logic [3:0]  pend_dp_reg;
   logic        pend_valid_reg;
   logic        blink_phase_reg;

   logic [3:0]  digit_out_reg, digit_out_next;
   logic [3:0]  an_reg, an_next;
   logic        dp_reg, dp_next;
   logic        frame_tick_reg;

   logic [3:0]  nib_zero;
   logic [3:0]  blank_vec;

   display_prescaler #(.DIV(REFRESH_DIV)) u_slot_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .tc    (slot_end)
   );

   assign frame_end = slot_end && (idx_reg == scan_idx_t'(NUM_DIGITS - 1));

   display_prescaler #(.DIV(BLINK_DIV)) u_frame_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (frame_end),
      .tc    (blink_wrap)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
         assign nib_zero[gi] = (disp_digits_reg[gi*4 +: 4] == 4'd0);
      end
   endgenerate

   // A digit is a leading zero only if it and every digit to its left are zero;
   // digit 0 always shows so a zero value still displays "0".
   always_comb begin
      blank_vec    = blink_mask & {NUM_DIGITS{blink_phase_reg}};
      blank_vec[3] = blank_vec[3] | (lz_blank & nib_zero[3]);
      blank_vec[2] = blank_vec[2] | (lz_blank & nib_zero[3] & nib_zero[2]);
      blank_vec[1] = blank_vec[1] | (lz_blank & nib_zero[3] & nib_zero[2] & nib_zero[1]);
   end

   always_comb begin
      digit_out_next = nibble_at(disp_digits_reg, idx_reg);
      an_next        = AN_SEL[idx_reg];
      dp_next        = ~disp_dp_reg[idx_reg];
      if (blank_vec[idx_reg]) begin
         an_next = AN_OFF;
         dp_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_reg         <= '0;
         disp_digits_reg <= '0;
         disp_dp_reg     <= '0;
         pend_digits_reg <= '0;
         pend_dp_reg     <= '0;
         pend_valid_reg  <= 1'b0;
         blink_phase_reg <= 1'b0;
         digit_out_reg   <= '0;
         an_reg          <= AN_OFF;
         dp_reg          <= 1'b1;
         frame_tick_reg  <= 1'b0;
      end else begin
         if (slot_end) begin
            idx_reg <= idx_reg + 2'd1;
         end
         if (blink_wrap) begin
            blink_phase_reg <= ~blink_phase_reg;
         end

         if (frame_end) begin
            // A load on the boundary itself bypasses the pending stage.
            if (load) begin
               disp_digits_reg <= digits_in;
               disp_dp_reg     <= dp_in;
            end else if (pend_valid_reg) begin
               disp_digits_reg <= pend_digits_reg;
               disp_dp_reg     <= pend_dp_reg;
            end
            pend_valid_reg <= 1'b0;
         end else if (load) begin
            pend_digits_reg <= digits_in;
            pend_dp_reg     <= dp_in;
            pend_valid_reg  <= 1'b1;
         end

         digit_out_reg  <= digit_out_next;
         an_reg         <= an_next;
         dp_reg         <= dp_next;
         frame_tick_reg <= frame_end;
      end
   end

   assign digit_out  = digit_out_reg;
   assign an         = an_reg;
   assign dp         = dp_reg;
   assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_display_scan_mux.sv
// Testbench for display_scan_mux with REFRESH_DIV=4, BLINK_DIV=2.
// Each frame is 16 cycles; expected per-cycle outputs are queued when the
// frame's stimulus is set up and popped as the DUT produces them.
module tb_display_scan_mux;

   logic        clk;
   logic        reset;
   logic [15:0] digits_in;
   logic        load;
   logic [3:0]  dp_in;
   logic [3:0]  blink_mask;
   logic        lz_blank;
   logic [3:0]  digit_out;
   logic [3:0]  an;
   logic        dp;
   logic        frame_tick;

   display_scan_mux #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .digits_in  (digits_in),
      .load       (load),
      .dp_in      (dp_in),
      .blink_mask (blink_mask),
      .lz_blank   (lz_blank),
      .digit_out  (digit_out),
      .an         (an),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Displayed value plus hand-derived expectations.
   // exp_an = {slot3, slot2, slot1, slot0}; exp_dp[s] = dp output in slot s.
   typedef struct {
      logic [15:0] digits;
      logic [3:0]  dpv;
      logic        lz;
      logic [15:0] exp_an;
      logic [3:0]  exp_dp;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [3:0] dig;
      logic       dp;
      logic       tick;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   frame_no = 0;

   vec_t tbl[8];
   vec_t prev, v_zero, v_6789, v_1259, v_9999, v_1111;

   function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p, input logic z,
                               input logic [15:0] ea, input logic [3:0] ed);
      vec_t v;
      v.digits = d; v.dpv = p; v.lz = z; v.exp_an = ea; v.exp_dp = ed;
      return v;
   endfunction

   task automatic drive_load(input int n, input int ln_a, input logic [15:0] da, input logic [3:0] pa,
                             input int ln_b, input logic [15:0] db, input logic [3:0] pb);
      if (n == ln_b) begin
         load = 1'b1; digits_in = db; dp_in = pb;
      end else if (n == ln_a) begin
         load = 1'b1; digits_in = da; dp_in = pa;
      end else begin
         load = 1'b0;
      end
   endtask

   // Runs one 16-cycle frame showing 'shown'; loads are driven at frame
   // cycle ln_a / ln_b (0 = at entry, 15 = sampled on the frame boundary).
   task automatic check_frame(input vec_t shown, input logic [3:0] mask,
                              input int ln_a, input logic [15:0] da, input logic [3:0] pa,
                              input int ln_b, input logic [15:0] db, input logic [3:0] pb);
      logic phase;
      exp_t e;
      phase = ((frame_no / 2) % 2) == 1;
      lz_blank   = shown.lz;
      blink_mask = mask;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            e.dig  = shown.digits[s*4 +: 4];
            e.an   = (phase && mask[s]) ? 4'b1111 : shown.exp_an[s*4 +: 4];
            e.dp   = (phase && mask[s]) ? 1'b1 : shown.exp_dp[s];
            e.tick = (s == 3) && (c == 3);
            sb.push_back(e);
         end
      end
      drive_load(0, ln_a, da, pa, ln_b, db, pb);
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (an !== e.an || digit_out !== e.dig || dp !== e.dp || frame_tick !== e.tick
             || $countones(~an) > 1) begin
            failures++;
            $display("FAIL frame%0d cyc%0d an/dig/dp/tick got=%b/%h/%b/%b exp=%b/%h/%b/%b",
                     frame_no, n, an, digit_out, dp, frame_tick, e.an, e.dig, e.dp, e.tick);
         end
         if (n < 16) drive_load(n, ln_a, da, pa, ln_b, db, pb);
      end
      $display("frame %0d shown=%h mask=%b lz=%b phase=%b", frame_no, shown.digits, mask, shown.lz, phase);
      frame_no++;
   endtask

   task automatic check_reset_state(input string name);
      checks++;
      if (an !== 4'b1111 || digit_out !== 4'h0 || dp !== 1'b1 || frame_tick !== 1'b0) begin
         failures++;
         $display("FAIL %s an/dig/dp/tick got=%b/%h/%b/%b exp=1111/0/1/0",
                  name, an, digit_out, dp, frame_tick);
      end
   endtask

   initial begin
      v_zero = mk(16'h0000, 4'b0000, 1'b0, 16'h7BDE, 4'b1111);
      tbl[0] = mk(16'h1234, 4'b0100, 1'b0, 16'h7BDE, 4'b1011);
      tbl[1] = mk(16'h0007, 4'b0000, 1'b1, 16'hFFFE, 4'b1111);
      tbl[2] = mk(16'h0A07, 4'b0000, 1'b1, 16'hFBDE, 4'b1111);
      tbl[3] = mk(16'h0007, 4'b0000, 1'b0, 16'h7BDE, 4'b1111);
      tbl[4] = mk(16'h0000, 4'b0001, 1'b1, 16'hFFFE, 4'b1110);
      tbl[5] = mk(16'h00F0, 4'b1111, 1'b1, 16'hFFDE, 4'b1100);
      tbl[6] = mk(16'h8000, 4'b1000, 1'b1, 16'h7BDE, 4'b0111);
      tbl[7] = mk(16'h0100, 4'b0010, 1'b1, 16'hFBDE, 4'b1101);
      v_6789 = mk(16'h6789, 4'b0001, 1'b0, 16'h7BDE, 4'b1110);
      v_1259 = mk(16'h1259, 4'b0000, 1'b0, 16'h7BDE, 4'b1111);
      v_9999 = mk(16'h9999, 4'b0000, 1'b0, 16'h7BDE, 4'b1111);
      v_1111 = mk(16'h1111, 4'b0000, 1'b0, 16'h7BDE, 4'b1111);

      reset = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
      blink_mask = '0; lz_blank = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset_state");
      reset = 1'b0;

      // Each frame shows the previous vector while the next one loads mid-frame.
      prev = v_zero;
      for (int k = 0; k < 8; k++) begin
         check_frame(prev, 4'b0000, 0, tbl[k].digits, tbl[k].dpv, -1, '0, '0);
         prev = tbl[k];
      end

      // Two loads in one frame: the later one wins.
      check_frame(prev, 4'b0000, 0, 16'h4321, 4'b0000, 7, 16'h6789, 4'b0001);
      check_frame(v_6789, 4'b0000, 0, 16'h1259, 4'b0000, -1, '0, '0);

      // Blink on digits 0-1 across two phase windows; last frame loads on the boundary.
      for (int b = 0; b < 4; b++) begin
         check_frame(v_1259, 4'b0011, (b == 3) ? 15 : -1, 16'h9999, 4'b0000, -1, '0, '0);
      end
      check_frame(v_9999, 4'b0000, 1, 16'h1111, 4'b0000, -1, '0, '0);
      check_frame(v_1111, 4'b0000, -1, '0, '0, -1, '0, '0);

      // Reset during slot 2 with a load pending.
      load = 1'b1; digits_in = 16'h5555; dp_in = 4'b1111;
      @(negedge clk);
      load = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("mid_frame_reset");
      reset = 1'b0;
      frame_no = 0;
      check_frame(v_zero, 4'b0000, -1, '0, '0, -1, '0, '0);
      check_frame(v_zero, 4'b0000, -1, '0, '0, -1, '0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
